annul_mux_arbiter: RTL

- Round-robin arbiter that shares one output pipeline register between N valid/ready requesters.
- Datapath is annul-and-OR, not a mux: every non-granted input word is gated to zero, all words are OR-reduced, and the result is loaded into a one-entry output register.
- Grant locks for a whole packet: it is held until the beat with `last` set is accepted.
- Used wherever several producers feed one downstream consumer of packetised words.

---
 rtl/annul_mux_arbiter_pkg.sv | 18 +
 rtl/annul.sv | 22 ++
 rtl/annul_mux_arbiter_rr_grant_select.sv | 40 ++++
 rtl/annul_mux_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/annul_mux_arbiter_pkg.sv
// Shared types and helpers for the annul-and-OR round-robin arbiter.
// Holds the FSM encoding, the index-width helper and the annul style names.
package annul_mux_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   localparam string IMPL_AND = "AND";
   localparam string IMPL_MUX = "MUX";

   // max(1, clog2(n)): a single requester still needs a 1-bit index port
   function automatic int unsigned index_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/annul.sv
// Annul stage: passes the word through or forces it to zero.
// "MUX" uses a select; any other style (including unknown) uses AND gating.
module annul
   import annul_mux_arbiter_pkg::*;
#(
   parameter int unsigned WORD_WIDTH     = 8,
   parameter string       IMPLEMENTATION = "AND"
) (
   input  logic                  i_annul,
   input  logic [WORD_WIDTH-1:0] i_data,
   output logic [WORD_WIDTH-1:0] o_data
);

   generate
      if (IMPLEMENTATION == IMPL_MUX) begin : g_mux
         assign o_data = i_annul ? '0 : i_data;
      end else begin : g_and
         assign o_data = i_data & {WORD_WIDTH{~i_annul}};
      end
   endgenerate

endmodule

// File: rtl/annul_mux_arbiter_rr_grant_select.sv
// Combinational round-robin pick: first valid requester at or above the
// pointer, wrapping to 0, returned as one-hot grant plus binary index.
module rr_grant_select
   import annul_mux_arbiter_pkg::*;
#(
   parameter  int unsigned INPUT_COUNT = 4,
   localparam int unsigned INDEX_WIDTH = index_width(INPUT_COUNT)
) (
   input  logic [INDEX_WIDTH-1:0] i_ptr,
   input  logic [INPUT_COUNT-1:0] i_valid,
   output logic [INPUT_COUNT-1:0] o_grant,
   output logic [INDEX_WIDTH-1:0] o_index
);

   int unsigned            w_cand;
   logic [INDEX_WIDTH-1:0] w_cand_idx;
   logic                   w_found;

   always_comb begin
      o_grant    = '0;
      o_index    = '0;
      w_found    = 1'b0;
      w_cand     = 0;
      w_cand_idx = '0;
      for (int unsigned k = 0; k < INPUT_COUNT; k++) begin
         // explicit wrap so non-power-of-2 counts never alias via overflow
         w_cand = 32'(i_ptr) + k;
         if (w_cand >= INPUT_COUNT) begin
            w_cand = w_cand - INPUT_COUNT;
         end
         w_cand_idx = INDEX_WIDTH'(w_cand);
         if (!w_found && i_valid[w_cand_idx]) begin
            w_found             = 1'b1;
            o_grant[w_cand_idx] = 1'b1;
            o_index             = w_cand_idx;
         end
      end
   end

endmodule

// File: rtl/annul_mux_arbiter.sv
// Round-robin packet arbiter: N valid/ready requesters share one output
// register; the granted word is kept by annulling all others and OR-reducing.
module annul_mux_arbiter
   import annul_mux_arbiter_pkg::*;
#(
   parameter  int unsigned WORD_WIDTH     = 8,
   parameter  int unsigned INPUT_COUNT    = 4,
   parameter  string       IMPLEMENTATION = "AND",
   localparam int unsigned INDEX_WIDTH    = index_width(INPUT_COUNT)
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [INPUT_COUNT-1:0]            in_valid,
   output logic [INPUT_COUNT-1:0]            in_ready,
   input  logic [INPUT_COUNT*WORD_WIDTH-1:0] in_data,
   input  logic [INPUT_COUNT-1:0]            in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WORD_WIDTH-1:0]             out_data,
   output logic                              out_last,
   output logic [INDEX_WIDTH-1:0]            out_index
);

   arb_state_t             r_state;
   arb_state_t             w_state_next;
   logic [INDEX_WIDTH-1:0] r_ptr;
   logic [INDEX_WIDTH-1:0] r_lock_idx;
   logic [INDEX_WIDTH-1:0] w_sel_idx;
   logic [INDEX_WIDTH-1:0] w_gnt_idx;
   logic [INDEX_WIDTH-1:0] w_ptr_next;
   logic [INPUT_COUNT-1:0] w_sel_onehot;
   logic [INPUT_COUNT-1:0] w_gnt_onehot;
   logic                   w_load_ok;
   logic                   w_xfer;
   logic                   w_gnt_last;
   logic [WORD_WIDTH-1:0]  w_annulled [INPUT_COUNT];
   logic [WORD_WIDTH-1:0]  w_or_data;

   logic                   r_out_valid;
   logic [WORD_WIDTH-1:0]  r_out_data;
   logic                   r_out_last;
   logic [INDEX_WIDTH-1:0] r_out_index;

   rr_grant_select #(
      .INPUT_COUNT (INPUT_COUNT)
   ) u_sel (
      .i_ptr   (r_ptr),
      .i_valid (in_valid),
      .o_grant (w_sel_onehot),
      .o_index (w_sel_idx)
   );

   assign w_load_ok = ~r_out_valid | out_ready;

   always_comb begin
      w_gnt_onehot = w_sel_onehot;
      w_gnt_idx    = w_sel_idx;
      if (r_state == ST_LOCKED) begin
         w_gnt_idx    = r_lock_idx;
         w_gnt_onehot = '0;
         for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            w_gnt_onehot[i] = (r_lock_idx == INDEX_WIDTH'(i));
         end
      end
   end

   // ready is forced low while reset is held, even if a requester is valid
   assign in_ready   = (reset_n && w_load_ok) ? w_gnt_onehot : '0;
   assign w_xfer     = |(in_valid & in_ready);
   assign w_gnt_last = |(in_last & w_gnt_onehot);
   assign w_ptr_next = (w_gnt_idx == INDEX_WIDTH'(INPUT_COUNT - 1)) ?
                       '0 : w_gnt_idx + INDEX_WIDTH'(1);

   generate
      for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_annul
         annul #(
            .WORD_WIDTH     (WORD_WIDTH),
            .IMPLEMENTATION (IMPLEMENTATION)
         ) u_annul (
            .i_annul (~w_gnt_onehot[gi]),
            .i_data  (in_data[gi*WORD_WIDTH +: WORD_WIDTH]),
            .o_data  (w_annulled[gi])
         );
      end
   endgenerate

   always_comb begin
      w_or_data = '0;
      for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
         w_or_data = w_or_data | w_annulled[i];
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer && !w_gnt_last) begin
               w_state_next = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (w_xfer && w_gnt_last) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_lock_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && w_xfer && !w_gnt_last) begin
            r_lock_idx <= w_gnt_idx;
         end
         if (w_xfer && w_gnt_last) begin
            r_ptr <= w_ptr_next;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_index <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_or_data;
         r_out_last  <= w_gnt_last;
         r_out_index <= w_gnt_idx;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_index = r_out_index;

endmodule
